// File: rtl/imem_loader.sv
`default_nettype none
//==============================================================================
// Module  : imem_loader
// Brief   : Assembles address+data frames from a slow asynchronous byte strobe
//           and issues one timed imem write per frame while in MEMLOAD mode.
// Revision: 1.0
//==============================================================================
module imem_loader #(
    parameter int ADDR_WIDTH     = 10,
    parameter int DATA_WIDTH     = 40,
    parameter int BYTES_PER_WORD = 7,
    parameter int WRITE_CYCLES   = 2
) (
    input  logic                  clk_int,
    input  logic                  reset,
    input  logic                  mode_memload,
    input  logic                  byte_strobe,
    input  logic [7:0]            byte_in,
    output logic [ADDR_WIDTH-1:0] imem_write_adr,
    output logic [DATA_WIDTH-1:0] imem_in,
    output logic                  imem_write_en,
    output logic                  busy,
    output logic                  overrun,
    output logic [ADDR_WIDTH:0]   word_count
);

    localparam int c_PAYLOAD_W = ADDR_WIDTH + DATA_WIDTH;
    localparam int c_IDX_W     = $clog2(BYTES_PER_WORD + 1);

    localparam logic [c_IDX_W-1:0] c_IDX_LAST   = c_IDX_W'(BYTES_PER_WORD);
    localparam logic [2:0]         c_TIMER_LOAD = 3'(WRITE_CYCLES);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_COLLECT = 2'd1;
    localparam logic [1:0] c_ST_WRITE   = 2'd2;

    logic                   r_strobe_s1, r_strobe_s2, r_strobe_prev;
    logic [7:0]             r_byte_s1, r_byte_s2;
    logic [1:0]             r_state, w_state_next;
    logic [c_IDX_W-1:0]     r_index, w_index_next, w_index_inc;
    logic [c_PAYLOAD_W-1:0] r_shift, w_shift_next, w_shift_in;
    logic [2:0]             r_timer, w_timer_next;
    logic [ADDR_WIDTH-1:0]  r_adr, w_adr_next;
    logic [DATA_WIDTH-1:0]  r_data, w_data_next;
    logic [ADDR_WIDTH:0]    r_count, w_count_next;
    logic                   r_overrun, w_overrun_next;
    logic                   w_edge;

    always_ff @(posedge clk_int) begin
        if (reset) begin
            r_strobe_s1   <= 1'b0;
            r_strobe_s2   <= 1'b0;
            r_strobe_prev <= 1'b0;
            r_byte_s1     <= 8'h00;
            r_byte_s2     <= 8'h00;
        end else begin
            r_strobe_s1   <= byte_strobe;
            r_strobe_s2   <= r_strobe_s1;
            r_strobe_prev <= r_strobe_s2;
            r_byte_s1     <= byte_in;
            r_byte_s2     <= r_byte_s1;
        end
    end

    assign w_edge      = r_strobe_s2 & ~r_strobe_prev;
    assign w_index_inc = r_index + 1'b1;
    // Only the low ADDR+DATA bits are kept; unused top bits of byte 0 fall off.
    assign w_shift_in  = (r_shift << 8) | {{(c_PAYLOAD_W-8){1'b0}}, r_byte_s2};

    always_ff @(posedge clk_int) begin
        if (reset) begin
            r_state   <= c_ST_IDLE;
            r_index   <= '0;
            r_shift   <= '0;
            r_timer   <= 3'd0;
            r_adr     <= '0;
            r_data    <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_index   <= w_index_next;
            r_shift   <= w_shift_next;
            r_timer   <= w_timer_next;
            r_adr     <= w_adr_next;
            r_data    <= w_data_next;
            r_count   <= w_count_next;
            r_overrun <= w_overrun_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_index_next   = r_index;
        w_shift_next   = r_shift;
        w_timer_next   = r_timer;
        w_adr_next     = r_adr;
        w_data_next    = r_data;
        w_count_next   = r_count;
        w_overrun_next = r_overrun;
        imem_write_en  = 1'b0;
        busy           = 1'b0;

        case (r_state)
            c_ST_COLLECT: busy = 1'b1;
            c_ST_WRITE: begin
                busy          = 1'b1;
                imem_write_en = 1'b1;
            end
            default: ;
        endcase

        // Mode exit wins over any strobe edge and truncates a running write.
        if (!mode_memload) begin
            w_state_next = c_ST_IDLE;
            w_index_next = '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_edge) begin
                        w_shift_next = {{(c_PAYLOAD_W-8){1'b0}}, r_byte_s2};
                        w_index_next = c_IDX_W'(1);
                        w_state_next = c_ST_COLLECT;
                    end
                end
                c_ST_COLLECT: begin
                    if (w_edge) begin
                        w_shift_next = w_shift_in;
                        w_index_next = w_index_inc;
                        if (w_index_inc == c_IDX_LAST) begin
                            w_adr_next   = w_shift_in[c_PAYLOAD_W-1:DATA_WIDTH];
                            w_data_next  = w_shift_in[DATA_WIDTH-1:0];
                            w_timer_next = c_TIMER_LOAD;
                            w_state_next = c_ST_WRITE;
                        end
                    end
                end
                c_ST_WRITE: begin
                    if (w_edge) begin
                        w_overrun_next = 1'b1;
                    end
                    if (r_timer == 3'd1) begin
                        if (r_count != '1) begin
                            w_count_next = r_count + 1'b1;
                        end
                        w_index_next = '0;
                        w_state_next = c_ST_IDLE;
                    end else begin
                        w_timer_next = r_timer - 3'd1;
                    end
                end
                default: w_state_next = c_ST_IDLE;
            endcase
        end
    end

    assign imem_write_adr = r_adr;
    assign imem_in        = r_data;
    assign overrun        = r_overrun;
    assign word_count     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
//==============================================================================
// Module  : tb_imem_loader
// Brief   : Checks imem_loader (2- and 4-cycle write variants) against a
//           frame-level model every cycle, plus hand-computed expectations.
// Revision: 1.0
//==============================================================================
module tb_imem_loader;

    logic clk_int = 1'b0;
    always #5 clk_int = ~clk_int;

    logic       r_reset, r_mode, r_strobe;
    logic [7:0] r_byte;

    logic        w_we   [2];
    logic        w_busy [2];
    logic        w_ovr  [2];
    logic [9:0]  w_adr  [2];
    logic [39:0] w_dat  [2];
    logic [10:0] w_cnt  [2];

    imem_loader u_dut2 (
        .clk_int        (clk_int),
        .reset          (r_reset),
        .mode_memload   (r_mode),
        .byte_strobe    (r_strobe),
        .byte_in        (r_byte),
        .imem_write_adr (w_adr[0]),
        .imem_in        (w_dat[0]),
        .imem_write_en  (w_we[0]),
        .busy           (w_busy[0]),
        .overrun        (w_ovr[0]),
        .word_count     (w_cnt[0])
    );

    imem_loader #(.WRITE_CYCLES(4)) u_dut4 (
        .clk_int        (clk_int),
        .reset          (r_reset),
        .mode_memload   (r_mode),
        .byte_strobe    (r_strobe),
        .byte_in        (r_byte),
        .imem_write_adr (w_adr[1]),
        .imem_in        (w_dat[1]),
        .imem_write_en  (w_we[1]),
        .busy           (w_busy[1]),
        .overrun        (w_ovr[1]),
        .word_count     (w_cnt[1])
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int rise_cyc = 0;

    always @(posedge clk_int) cyc <= cyc + 1;

    // Frame-level model: pad strobe is seen by the loader 2 clocks after it
    // is sampled; each instance collects 7 bytes then writes for WC cycles.
    logic        mdl_live = 1'b0;
    logic        mdl_hs1, mdl_hs2, mdl_hs3;
    logic [7:0]  mdl_hb1, mdl_hb2;
    int          mdl_n   [2];
    int          mdl_rem [2];
    logic [55:0] mdl_frame [2];
    logic [9:0]  mdl_adr [2];
    logic [39:0] mdl_dat [2];
    logic [10:0] mdl_cnt [2];
    logic        mdl_ovr [2];

    always @(posedge clk_int) begin : model
        logic        edge_k;
        logic [7:0]  b_k;
        logic [55:0] f;
        edge_k = mdl_hs2 & ~mdl_hs3;
        b_k    = mdl_hb2;
        mdl_live <= 1'b1;
        if (r_reset) begin
            mdl_hs1 <= 1'b0; mdl_hs2 <= 1'b0; mdl_hs3 <= 1'b0;
            mdl_hb1 <= 8'h00; mdl_hb2 <= 8'h00;
            for (int i = 0; i < 2; i++) begin
                mdl_n[i] <= 0; mdl_rem[i] <= 0; mdl_frame[i] <= '0;
                mdl_adr[i] <= '0; mdl_dat[i] <= '0; mdl_cnt[i] <= '0; mdl_ovr[i] <= 1'b0;
            end
        end else begin
            mdl_hs1 <= r_strobe; mdl_hs2 <= mdl_hs1; mdl_hs3 <= mdl_hs2;
            mdl_hb1 <= r_byte;   mdl_hb2 <= mdl_hb1;
            for (int i = 0; i < 2; i++) begin
                if (!r_mode) begin
                    mdl_n[i]   <= 0;
                    mdl_rem[i] <= 0;
                end else if (mdl_rem[i] > 0) begin
                    if (edge_k) mdl_ovr[i] <= 1'b1;
                    mdl_rem[i] <= mdl_rem[i] - 1;
                    if (mdl_rem[i] == 1 && mdl_cnt[i] != 11'h7FF) mdl_cnt[i] <= mdl_cnt[i] + 11'd1;
                end else if (edge_k) begin
                    f = (mdl_n[i] == 0) ? {48'h0, b_k} : ((mdl_frame[i] << 8) | {48'h0, b_k});
                    if (mdl_n[i] + 1 == 7) begin
                        mdl_adr[i] <= f[49:40];
                        mdl_dat[i] <= f[39:0];
                        mdl_rem[i] <= (i == 0) ? 2 : 4;
                        mdl_n[i]   <= 0;
                    end else begin
                        mdl_n[i]     <= mdl_n[i] + 1;
                        mdl_frame[i] <= f;
                    end
                end
            end
        end
    end

    always @(negedge clk_int) begin
        if (mdl_live) begin
            for (int i = 0; i < 2; i++) begin
                logic e_we, e_busy;
                e_we   = (mdl_rem[i] > 0);
                e_busy = (mdl_rem[i] > 0) || (mdl_n[i] > 0);
                n_cmp++;
                if ({w_we[i], w_busy[i], w_ovr[i], w_cnt[i], w_adr[i], w_dat[i]} !==
                    {e_we, e_busy, mdl_ovr[i], mdl_cnt[i], mdl_adr[i], mdl_dat[i]}) begin
                    n_bad++;
                    $display("FAIL model inst%0d cyc %0d: got we=%b busy=%b ovr=%b cnt=%h adr=%h dat=%h, want we=%b busy=%b ovr=%b cnt=%h adr=%h dat=%h",
                             i, cyc, w_we[i], w_busy[i], w_ovr[i], w_cnt[i], w_adr[i], w_dat[i],
                             e_we, e_busy, mdl_ovr[i], mdl_cnt[i], mdl_adr[i], mdl_dat[i]);
                end
            end
        end
    end

    // Write-pulse start cycle and length for each instance.
    logic pw_prev  [2] = '{1'b0, 1'b0};
    int   pw_start [2] = '{-100, -100};
    int   pw_len   [2] = '{0, 0};
    always @(negedge clk_int) begin
        for (int i = 0; i < 2; i++) begin
            if (w_we[i] === 1'b1 && pw_prev[i] !== 1'b1) begin
                pw_start[i] <= cyc;
                pw_len[i]   <= 1;
            end else if (w_we[i] === 1'b1) begin
                pw_len[i] <= pw_len[i] + 1;
            end
            pw_prev[i] <= w_we[i];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int lo, input int hi);
        r_byte   = b;
        r_strobe = 1'b0;
        repeat (lo) @(negedge clk_int);
        r_strobe = 1'b1;
        rise_cyc = cyc;
        repeat (hi) @(negedge clk_int);
        r_strobe = 1'b0;
    endtask

    task automatic send_frame(input logic [55:0] f, input int lo, input int hi);
        for (int j = 0; j < 7; j++) send_byte(f[55-8*j -: 8], lo, hi);
        repeat (2) @(negedge clk_int);
    endtask

    task automatic do_reset();
        r_reset  = 1'b1;
        r_strobe = 1'b0;
        repeat (2) @(negedge clk_int);
        r_reset = 1'b0;
        @(negedge clk_int);
    endtask

    // Drops mode during the first write cycle of a frame.
    task automatic truncate_frame(input logic [55:0] f, input logic [10:0] exp_cnt);
        for (int j = 0; j < 6; j++) send_byte(f[55-8*j -: 8], 3, 1);
        r_byte   = f[7:0];
        r_strobe = 1'b0;
        repeat (3) @(negedge clk_int);
        r_strobe = 1'b1;
        @(negedge clk_int);
        r_strobe = 1'b0;
        repeat (2) @(negedge clk_int);
        check("trunc_we_on", {62'h0, w_we[0], w_we[1]}, 64'h3);
        r_mode = 1'b0;
        @(negedge clk_int);
        check("trunc_we_off", {62'h0, w_we[0], w_we[1]}, 64'h0);
        check("trunc_busy", {62'h0, w_busy[0], w_busy[1]}, 64'h0);
        repeat (4) @(negedge clk_int);
        check("trunc_cnt2", {53'h0, w_cnt[0]}, {53'h0, exp_cnt});
        check("trunc_cnt4", {53'h0, w_cnt[1]}, {53'h0, exp_cnt});
        check("trunc_adr", {54'h0, w_adr[0]}, {54'h0, f[49:40]});
        r_mode = 1'b1;
        repeat (2) @(negedge clk_int);
    endtask

    initial begin
        logic [55:0] fr;
        r_reset = 1'b1; r_mode = 1'b0; r_strobe = 1'b1; r_byte = 8'h00;
        repeat (2) @(negedge clk_int);
        for (int i = 0; i < 2; i++)
            check("reset_state", {w_we[i], w_busy[i], w_ovr[i], w_cnt[i], w_adr[i], w_dat[i]}, 64'h0);
        r_reset = 1'b0;
        repeat (3) @(negedge clk_int);
        r_mode = 1'b1;
        repeat (6) @(negedge clk_int);
        check("strobe_high_no_start", {62'h0, w_busy[0], w_busy[1]}, 64'h0);
        r_strobe = 1'b0;
        repeat (4) @(negedge clk_int);

        // Single frame, 4-high / 4-low strobe
        send_frame(56'h03123456789ABC, 4, 4);
        repeat (4) @(negedge clk_int);
        check("single_latency", 64'(pw_start[0] - rise_cyc), 64'd3);
        check("single_len2", 64'(pw_len[0]), 64'd2);
        check("single_len4", 64'(pw_len[1]), 64'd4);
        check("single_adr", {54'h0, w_adr[0]}, 64'h312);
        check("single_dat", {24'h0, w_dat[0]}, 64'h3456789ABC);
        check("single_cnt", {53'h0, w_cnt[0]}, 64'd1);
        check("single_busy", {63'h0, w_busy[0]}, 64'd0);

        // Back-to-back frames, including unused top bits set in byte 0
        do_reset();
        send_frame({6'h00, 10'h000, 40'h0102030405}, 3, 1);
        check("b2b0_adr", {54'h0, w_adr[0]}, 64'h000);
        send_frame({6'h00, 10'h001, 40'hFFFFFFFFFF}, 3, 1);
        check("b2b1_dat", {24'h0, w_dat[0]}, 64'hFFFFFFFFFF);
        send_frame({6'h3F, 10'h3FF, 40'hA5A5A5A5A5}, 3, 1);
        repeat (4) @(negedge clk_int);
        check("b2b2_adr", {54'h0, w_adr[1]}, 64'h3FF);
        check("b2b2_dat", {24'h0, w_dat[1]}, 64'hA5A5A5A5A5);
        check("b2b_cnt", {42'h0, w_cnt[0], w_cnt[1]}, {42'h0, 11'd3, 11'd3});
        check("b2b_ovr", {62'h0, w_ovr[0], w_ovr[1]}, 64'h0);

        // Overrun: strobe re-raised one cycle after the last frame byte
        do_reset();
        fr = 56'h0155AABBCCDDEE;
        for (int j = 0; j < 6; j++) send_byte(fr[55-8*j -: 8], 4, 1);
        send_byte(fr[7:0], 4, 1);
        r_byte = 8'h99;
        @(negedge clk_int);
        r_strobe = 1'b1;
        @(negedge clk_int);
        r_strobe = 1'b0;
        repeat (8) @(negedge clk_int);
        check("ovr_set", {62'h0, w_ovr[0], w_ovr[1]}, 64'h3);
        check("ovr_adr", {54'h0, w_adr[1]}, 64'h155);
        check("ovr_dat", {24'h0, w_dat[1]}, 64'hAABBCCDDEE);
        send_frame(56'h00421122334455, 3, 1);
        repeat (4) @(negedge clk_int);
        check("ovr_next_adr", {54'h0, w_adr[1]}, 64'h042);
        check("ovr_next_dat", {24'h0, w_dat[1]}, 64'h1122334455);
        check("ovr_sticky", {62'h0, w_ovr[0], w_ovr[1]}, 64'h3);
        check("ovr_cnt", {53'h0, w_cnt[1]}, 64'd2);
        do_reset();
        check("ovr_clear", {62'h0, w_ovr[0], w_ovr[1]}, 64'h0);

        // Mode abort after 4 bytes, then a clean frame
        fr = 56'h03DEADBEEF0000;
        for (int j = 0; j < 4; j++) send_byte(fr[55-8*j -: 8], 3, 1);
        repeat (4) @(negedge clk_int);
        r_mode = 1'b0;
        @(negedge clk_int);
        check("abort_busy", {62'h0, w_busy[0], w_busy[1]}, 64'h0);
        repeat (3) @(negedge clk_int);
        r_mode = 1'b1;
        repeat (2) @(negedge clk_int);
        send_frame(56'h0123C0DE600D01, 3, 1);
        repeat (4) @(negedge clk_int);
        check("abort_adr", {54'h0, w_adr[0]}, 64'h123);
        check("abort_dat", {24'h0, w_dat[0]}, 64'hC0DE600D01);
        check("abort_cnt", {53'h0, w_cnt[0]}, 64'd1);
        truncate_frame(56'h02770102030405, 11'd1);

        // Saturation of word_count
        do_reset();
        for (int i = 0; i < 2047; i++) begin
            logic [23:0] d;
            d = 24'(i * 7);
            send_frame({6'h00, 10'(i), d, 16'hBEEF}, 3, 1);
        end
        repeat (4) @(negedge clk_int);
        check("sat_cnt", {42'h0, w_cnt[0], w_cnt[1]}, {42'h0, 11'h7FF, 11'h7FF});
        send_frame({6'h15, 10'h2AB, 40'h6677889900}, 3, 1);
        repeat (4) @(negedge clk_int);
        check("sat_hold", {42'h0, w_cnt[0], w_cnt[1]}, {42'h0, 11'h7FF, 11'h7FF});
        check("sat_adr", {54'h0, w_adr[0]}, 64'h2AB);
        check("sat_dat", {24'h0, w_dat[0]}, 64'h6677889900);
        truncate_frame(56'h00101234567890, 11'h7FF);

        repeat (5) @(negedge clk_int);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
